// File: rtl/gem_tx_r_status_decoder.sv
// rtl/gem_tx_r_status_decoder.sv - GEM TX descriptor decode, end-of-frame toggle handshake and writeback
module gem_tx_r_status_decoder #(
  parameter int STATUS_TIMEOUT = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [31:0] desc_word,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [13:0] cmd_length,
  output logic        cmd_last,
  output logic        cmd_no_crc,
  input  logic        cmd_done,
  output logic        dma_tx_end_tog,
  input  logic        dma_tx_status_tog,
  input  logic [3:0]  tx_r_status,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_word,
  output logic        used_hit,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_XFER, S_WAIT_STAT, S_WB} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(STATUS_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        wrap_q;
  logic [15:0] timer_q;
  logic        tog_prev_q;

  logic        desc_accept;
  logic        desc_used;
  logic        desc_empty;
  logic        status_edge;
  logic        timer_expired;

  logic        desc_ready_d;
  logic        cmd_valid_d;
  logic        wb_valid_d;
  logic        used_hit_d;
  logic        end_tog_d;
  logic        timer_clr;
  logic        fc_inc;
  logic [31:0] wb_word_d;
  logic        unused_desc_bits;

  assign unused_desc_bits = ^{desc_word[29:17], desc_word[14]};

  assign desc_accept   = desc_valid && (state == S_IDLE);
  assign desc_used     = desc_word[31];
  assign desc_empty    = (desc_word[13:0] == 14'd0);
  assign status_edge   = dma_tx_status_tog ^ tog_prev_q;
  assign timer_expired = (timer_q == TIMEOUT_LAST);

  // Writeback layout: used set, wrap, GEM status remapped to descriptor bits 29:26.
  function automatic logic [31:0] pack_wb(input logic       wrap,
                                          input logic [3:0] st,
                                          input logic       timeout,
                                          input logic       no_crc,
                                          input logic       last,
                                          input logic [13:0] len);
    return {1'b1, wrap, st[1], st[0], st[3] | timeout, st[2], 9'd0,
            no_crc, last, 1'b0, len};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (desc_accept && !desc_used) begin
          if (!desc_empty) begin
            state_nxt = S_CMD;
          end else if (desc_word[15]) begin
            state_nxt = S_WAIT_STAT;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_CMD: begin
        if (cmd_ready) begin
          state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (cmd_done) begin
          state_nxt = cmd_last ? S_WAIT_STAT : S_WB;
        end
      end
      S_WAIT_STAT: begin
        if (status_edge || timer_expired) begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        if (wb_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs; a zero-length buffer behaves as an immediate cmd_done.
  always_comb begin
    desc_ready_d = (state_nxt == S_IDLE);
    cmd_valid_d  = (state_nxt == S_CMD);
    wb_valid_d   = (state_nxt == S_WB);
    used_hit_d   = desc_accept && desc_used;
    end_tog_d    = dma_tx_end_tog;
    timer_clr    = 1'b0;
    fc_inc       = 1'b0;
    wb_word_d    = wb_word;
    case (state)
      S_IDLE: begin
        if (desc_accept && !desc_used && desc_empty) begin
          if (desc_word[15]) begin
            end_tog_d = ~dma_tx_end_tog;
            timer_clr = 1'b1;
          end else begin
            wb_word_d = pack_wb(desc_word[30], 4'd0, 1'b0, desc_word[16], 1'b0, 14'd0);
          end
        end
      end
      S_XFER: begin
        if (cmd_done) begin
          if (cmd_last) begin
            end_tog_d = ~dma_tx_end_tog;
            timer_clr = 1'b1;
          end else begin
            wb_word_d = pack_wb(wrap_q, 4'd0, 1'b0, cmd_no_crc, 1'b0, cmd_length);
          end
        end
      end
      S_WAIT_STAT: begin
        if (status_edge) begin
          fc_inc    = 1'b1;
          wb_word_d = pack_wb(wrap_q, tx_r_status, 1'b0, cmd_no_crc, 1'b1, cmd_length);
        end else if (timer_expired) begin
          fc_inc    = 1'b1;
          wb_word_d = pack_wb(wrap_q, 4'd0, 1'b1, cmd_no_crc, 1'b1, cmd_length);
        end
      end
      default: ;
    endcase
  end

  // The toggle history loads even under reset so leaving reset never looks like an edge.
  always_ff @(posedge clock) begin
    tog_prev_q <= dma_tx_status_tog;
    if (reset) begin
      desc_ready     <= 1'b1;
      cmd_valid      <= 1'b0;
      wb_valid       <= 1'b0;
      used_hit       <= 1'b0;
      dma_tx_end_tog <= 1'b0;
      wb_word        <= 32'd0;
      frame_count    <= 16'd0;
      cmd_length     <= 14'd0;
      cmd_last       <= 1'b0;
      cmd_no_crc     <= 1'b0;
      wrap_q         <= 1'b0;
      timer_q        <= 16'd0;
    end else begin
      desc_ready     <= desc_ready_d;
      cmd_valid      <= cmd_valid_d;
      wb_valid       <= wb_valid_d;
      used_hit       <= used_hit_d;
      dma_tx_end_tog <= end_tog_d;
      wb_word        <= wb_word_d;
      if (desc_accept) begin
        cmd_length <= desc_word[13:0];
        cmd_last   <= desc_word[15];
        cmd_no_crc <= desc_word[16];
        wrap_q     <= desc_word[30];
      end
      if (timer_clr) begin
        timer_q <= 16'd0;
      end else if (state == S_WAIT_STAT) begin
        timer_q <= timer_q + 16'd1;
      end
      if (fc_inc) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gem_tx_r_status_decoder.sv
// tb/tb_gem_tx_r_status_decoder.sv - directed and randomized checks of gem_tx_r_status_decoder
module tb_gem_tx_r_status_decoder;

  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [31:0] desc_word = 32'd0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [13:0] cmd_length;
  logic        cmd_last;
  logic        cmd_no_crc;
  logic        cmd_done = 1'b0;
  logic        dma_tx_end_tog;
  logic        dma_tx_status_tog = 1'b0;
  logic [3:0]  tx_r_status = 4'd0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_word;
  logic        used_hit;
  logic [15:0] frame_count;

  gem_tx_r_status_decoder #(.STATUS_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_word(desc_word),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_length(cmd_length),
    .cmd_last(cmd_last), .cmd_no_crc(cmd_no_crc), .cmd_done(cmd_done),
    .dma_tx_end_tog(dma_tx_end_tog), .dma_tx_status_tog(dma_tx_status_tog),
    .tx_r_status(tx_r_status), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_word(wb_word), .used_hit(used_hit), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one descriptor at a time, tracked by what the data mover and GEM still owe it.
  typedef enum int {M_FREE, M_OFFER_CMD, M_MOVING, M_AWAIT_STATUS, M_WRITEBACK} mstep_t;

  mstep_t      m_step = M_FREE;
  bit          live = 1'b0;
  bit          m_prev_tog = 1'b0;
  bit          m_wrap = 1'b0;
  int          m_since_tog = 0;
  int          m_frames = 0;
  logic        e_desc_ready = 1'b1;
  logic        e_cmd_valid = 1'b0;
  logic        e_wb_valid = 1'b0;
  logic        e_used_hit = 1'b0;
  logic        e_end_tog = 1'b0;
  logic [15:0] e_fc = 16'd0;
  logic [31:0] e_wb = 32'd0;
  logic [13:0] e_len = 14'd0;
  logic        e_last = 1'b0;
  logic        e_no_crc = 1'b0;

  function automatic logic [31:0] wb_expect(input bit wrap, input logic [3:0] st, input bit to,
                                            input bit no_crc, input bit last, input logic [13:0] len);
    logic [31:0] w;
    w = 32'h8000_0000;
    if (wrap)         w += 32'h4000_0000;
    if (st[1])        w += 32'h2000_0000;
    if (st[0])        w += 32'h1000_0000;
    if (st[3] || to)  w += 32'h0800_0000;
    if (st[2])        w += 32'h0400_0000;
    if (no_crc)       w += 32'h0001_0000;
    if (last)         w += 32'h0000_8000;
    w += {18'd0, len};
    return w;
  endfunction

  task automatic finish_buffer();
    if (e_last) begin
      e_end_tog   = ~e_end_tog;
      m_since_tog = 0;
      m_step      = M_AWAIT_STATUS;
    end else begin
      e_wb   = wb_expect(m_wrap, 4'h0, 1'b0, e_no_crc, 1'b0, e_len);
      m_step = M_WRITEBACK;
    end
  endtask

  task automatic close_frame(input logic [3:0] st, input bit to);
    m_frames++;
    e_fc   = 16'(m_frames % 65536);
    e_wb   = wb_expect(m_wrap, st, to, e_no_crc, 1'b1, e_len);
    m_step = M_WRITEBACK;
  endtask

  always @(posedge clock) begin : model
    bit edge_seen;
    edge_seen  = (dma_tx_status_tog != m_prev_tog);
    m_prev_tog = dma_tx_status_tog;
    if (reset) begin
      live = 1'b1; m_step = M_FREE; m_frames = 0; m_wrap = 1'b0;
      e_desc_ready = 1'b1; e_cmd_valid = 1'b0; e_wb_valid = 1'b0; e_used_hit = 1'b0;
      e_end_tog = 1'b0; e_fc = 16'd0; e_wb = 32'd0; e_len = 14'd0; e_last = 1'b0; e_no_crc = 1'b0;
    end else if (live) begin
      e_used_hit = 1'b0;
      case (m_step)
        M_FREE: if (desc_valid) begin
          e_len = desc_word[13:0]; e_last = desc_word[15];
          e_no_crc = desc_word[16]; m_wrap = desc_word[30];
          if (desc_word[31])   e_used_hit = 1'b1;
          else if (e_len != 0) m_step = M_OFFER_CMD;
          else                 finish_buffer();
        end
        M_OFFER_CMD: if (cmd_ready) m_step = M_MOVING;
        M_MOVING:    if (cmd_done) finish_buffer();
        M_AWAIT_STATUS: begin
          m_since_tog++;
          if (edge_seen)                close_frame(tx_r_status, 1'b0);
          else if (m_since_tog == TMO)  close_frame(4'h0, 1'b1);
        end
        M_WRITEBACK: if (wb_ready) m_step = M_FREE;
        default: m_step = M_FREE;
      endcase
      e_desc_ready = (m_step == M_FREE);
      e_cmd_valid  = (m_step == M_OFFER_CMD);
      e_wb_valid   = (m_step == M_WRITEBACK);
    end
  end

  always @(negedge clock) begin
    if (live) begin
      check("desc_ready", 32'(desc_ready), 32'(e_desc_ready));
      check("cmd_valid", 32'(cmd_valid), 32'(e_cmd_valid));
      check("wb_valid", 32'(wb_valid), 32'(e_wb_valid));
      check("used_hit", 32'(used_hit), 32'(e_used_hit));
      check("end_tog", 32'(dma_tx_end_tog), 32'(e_end_tog));
      check("frame_count", 32'(frame_count), 32'(e_fc));
      if (e_cmd_valid)
        check("cmd_payload", {16'd0, cmd_no_crc, cmd_last, cmd_length}, {16'd0, e_no_crc, e_last, e_len});
      if (e_wb_valid)
        check("wb_word", wb_word, e_wb);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic offer(input logic [31:0] w);
    int n;
    n = 0;
    desc_valid = 1'b1;
    desc_word  = w;
    while (desc_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    step();
    desc_valid = 1'b0;
    check("offer_accepted", 32'(n < 20), 32'd1);
  endtask

  task automatic cmd_handshake();
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
  endtask

  task automatic pulse_done();
    cmd_done = 1'b1; step(); cmd_done = 1'b0;
  endtask

  task automatic flip_status(input logic [3:0] st);
    tx_r_status = st;
    dma_tx_status_tog = ~dma_tx_status_tog;
    step();
  endtask

  task automatic wb_accept();
    wb_ready = 1'b1; step(); wb_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int n;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("rst_desc_ready", 32'(desc_ready), 32'd1);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_end_tog", 32'(dma_tx_end_tog), 32'd0);
    check("rst_wb_word", wb_word, 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);

    offer(32'h0000_8040);
    check("tc1_cmd_valid", 32'(cmd_valid), 32'd1);
    check("tc1_cmd_length", 32'(cmd_length), 32'd64);
    check("tc1_cmd_last", 32'(cmd_last), 32'd1);
    cmd_handshake();
    pulse_done();
    check("tc1_end_tog", 32'(dma_tx_end_tog), 32'd1);
    flip_status(4'h0);
    check("tc1_wb_valid", 32'(wb_valid), 32'd1);
    check("tc1_wb_word", wb_word, 32'h8000_8040);
    check("tc1_model_wb", e_wb, 32'h8000_8040);
    check("tc1_frame_count", 32'(frame_count), 32'd1);
    wb_accept();

    offer(32'h0000_0100);
    cmd_handshake();
    pulse_done();
    check("tc2_wb_valid", 32'(wb_valid), 32'd1);
    check("tc2_wb_word_a", wb_word, 32'h8000_0100);
    check("tc2_no_toggle", 32'(dma_tx_end_tog), 32'd1);
    wb_accept();
    offer(32'h4001_8020);
    check("tc2_cmd_no_crc", 32'(cmd_no_crc), 32'd1);
    cmd_handshake();
    pulse_done();
    flip_status(4'h0);
    check("tc2_wb_word_b", wb_word, 32'hC001_8020);
    check("tc2_frame_count", 32'(frame_count), 32'd2);
    wb_accept();

    offer(32'h8000_8040);
    check("tc3_used_hit", 32'(used_hit), 32'd1);
    check("tc3_cmd_valid", 32'(cmd_valid), 32'd0);
    check("tc3_desc_ready", 32'(desc_ready), 32'd1);
    step();
    check("tc3_used_hit_pulse", 32'(used_hit), 32'd0);
    check("tc3_wb_valid", 32'(wb_valid), 32'd0);

    offer(32'h0000_8010);
    cmd_handshake();
    pulse_done();
    flip_status(4'hF);
    check("tc4_status_bits", 32'(wb_word[29:26]), 32'hF);
    check("tc4_wb_word_err", wb_word, 32'hBC00_8010);
    wb_accept();

    offer(32'h0000_8010);
    cmd_handshake();
    pulse_done();
    n = 0;
    while (wb_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("tc4_timeout_latency", 32'(n), 32'(TMO));
    check("tc4_wb_word_timeout", wb_word, 32'h8800_8010);
    check("tc4_model_timeout", e_wb, 32'h8800_8010);
    check("tc4_frame_count", 32'(frame_count), 32'd4);
    wb_accept();

    offer(32'h0000_8010);
    cmd_handshake();
    pulse_done();
    repeat (TMO - 1) step();
    check("tc4_before_expiry", 32'(wb_valid), 32'd0);
    flip_status(4'h4);
    check("tc4_tie_wb_valid", 32'(wb_valid), 32'd1);
    check("tc4_tie_wb_word", wb_word, 32'h8400_8010);
    wb_accept();

    offer(32'h0001_0123);
    for (int i = 0; i < 5; i++) begin
      check("tc5_cmd_hold_valid", 32'(cmd_valid), 32'd1);
      check("tc5_cmd_hold_length", 32'(cmd_length), 32'h123);
      step();
    end
    cmd_handshake();
    pulse_done();
    for (int i = 0; i < 5; i++) begin
      check("tc5_wb_hold_valid", 32'(wb_valid), 32'd1);
      check("tc5_wb_hold_word", wb_word, 32'h8001_0123);
      step();
    end
    wb_accept();

    offer(32'h0000_8000);
    check("tc5_zero_len_no_cmd", 32'(cmd_valid), 32'd0);
    check("tc5_zero_len_toggle", 32'(dma_tx_end_tog), 32'd0);
    flip_status(4'h0);
    check("tc5_zero_len_wb", wb_word, 32'h8000_8000);
    check("tc5_frame_count", 32'(frame_count), 32'd6);
    wb_accept();

    offer(32'h0000_8008);
    cmd_handshake();
    pulse_done();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("tc6_desc_ready", 32'(desc_ready), 32'd1);
    check("tc6_end_tog", 32'(dma_tx_end_tog), 32'd0);
    check("tc6_wb_valid", 32'(wb_valid), 32'd0);
    check("tc6_frame_count", 32'(frame_count), 32'd0);
    flip_status(4'h3);
    repeat (3) step();
    check("tc6_late_edge_wb", 32'(wb_valid), 32'd0);
    check("tc6_late_edge_fc", 32'(frame_count), 32'd0);

    for (int c = 0; c < 4000; c++) begin
      desc_valid = ($urandom_range(0, 1) == 1);
      w = $urandom;
      if ($urandom_range(0, 4) != 0) w[31] = 1'b0;
      case ($urandom_range(0, 5))
        0:       w[13:0] = 14'd0;
        1, 2, 3: w[13:0] = 14'($urandom_range(1, 63));
        default: ;
      endcase
      desc_word   = w;
      cmd_ready   = ($urandom_range(0, 9) < 6);
      cmd_done    = ($urandom_range(0, 9) < 3);
      wb_ready    = ($urandom_range(0, 9) < 6);
      tx_r_status = 4'($urandom);
      if ($urandom_range(0, 99) < 12) dma_tx_status_tog = ~dma_tx_status_tog;
      reset = ($urandom_range(0, 599) == 0);
      step();
    end

    desc_valid = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0; wb_ready = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("wrap_start", 32'(frame_count), 32'd0);
    wb_ready  = 1'b1;
    desc_word = 32'h0000_8000;
    for (int f = 0; f < 65535; f++) begin
      desc_valid = 1'b1;
      step();
      desc_valid = 1'b0;
      dma_tx_status_tog = ~dma_tx_status_tog;
      step();
      step();
    end
    check("wrap_at_max", 32'(frame_count), 32'hFFFF);
    desc_valid = 1'b1;
    step();
    desc_valid = 1'b0;
    dma_tx_status_tog = ~dma_tx_status_tog;
    step();
    check("wrap_to_zero", 32'(frame_count), 32'd0);
    check("wrap_model_fc", 32'(e_fc), 32'd0);
    step();
    wb_ready = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gem_tx_r_status_decoder.md
# gem_tx_r_status_decoder

Transmit-side counterpart of the RX write-status path. The block accepts 32-bit GEM TX DMA descriptor control words and decodes them into buffer commands for the TX data mover. It runs the end-of-frame toggle handshake with the GEM TX FIFO interface and emits the descriptor writeback word, with the used bit and TX error status merged in. It sits between the TX descriptor fetch unit and the TX data mover / GEM `tx_r_*` side.

## Interface
- `STATUS_TIMEOUT`, default 4096: cycles to wait for the GEM status toggle before forcing a timeout writeback; legal range 2..65535.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `desc_valid` in 1: descriptor control word offered.
- `desc_ready` out 1: descriptor accepted when high together with `desc_valid`.
- `desc_word` in 32: descriptor control word. Fields: [31] used, [30] wrap, [16] no_crc, [15] last, [13:0] length.
- `cmd_valid` out 1: buffer command to the data mover.
- `cmd_ready` in 1: data mover accepts the command.
- `cmd_length` out 14: byte count to move.
- `cmd_last` out 1: final buffer of the frame.
- `cmd_no_crc` out 1: suppress FCS generation.
- `cmd_done` in 1: single-cycle pulse; all bytes of the current command have been pushed to GEM.
- `dma_tx_end_tog` out 1: toggles once per completed frame.
- `dma_tx_status_tog` in 1: GEM toggles this when `tx_r_status` is valid.
- `tx_r_status` in 4: [3] AHB error, [2] late collision, [1] retry limit exceeded, [0] underflow.
- `wb_valid` out 1: writeback word offered.
- `wb_ready` in 1: writeback accepted.
- `wb_word` out 32: descriptor writeback word.
- `used_hit` out 1: one-cycle pulse; a descriptor with the used bit already set was fetched.
- `frame_count` out 16: count of completed frames, wraps.

## Operation
- FSM states: IDLE, CMD, XFER, WAIT_STAT, WB.
- **IDLE**
  - `desc_ready`=1.
  - On accept, latch length, last, no_crc and wrap.
  - used=1: pulse `used_hit`, stay in IDLE, no command, no writeback.
  - used=0 and length≠0: go to CMD.
  - used=0 and length=0: skip the transfer and treat it as an immediate `cmd_done`. last=1 goes to WAIT_STAT (with the toggle); last=0 goes to WB.
- **CMD**
  - `cmd_valid`=1; `cmd_*` are held stable until `cmd_ready`.
  - On handshake go to XFER.
- **XFER**
  - Wait for `cmd_done`.
  - last=1: flip `dma_tx_end_tog`, clear the timeout counter, go to WAIT_STAT.
  - last=0: go to WB with status 0.
- **WAIT_STAT**
  - On a detected `dma_tx_status_tog` edge, capture `tx_r_status`, increment `frame_count`, go to WB.
  - When the counter reaches `STATUS_TIMEOUT`-1 without an edge, set the timeout flag, increment `frame_count`, go to WB.
- **WB**
  - `wb_valid`=1; `wb_word` is held stable until `wb_ready`, then go to IDLE.
- Writeback word:
  - [31]=1
  - [30]=wrap
  - [29]=status[1]
  - [28]=status[0]
  - [27]=status[3] OR timeout
  - [26]=status[2]
  - [16]=no_crc
  - [15]=last
  - [13:0]=length
  - All other bits are 0.
- Edge detect: a register holds the previous `dma_tx_status_tog`.
  - It loads the input every cycle, including during reset, so reset produces no spurious edge.
  - Edges outside WAIT_STAT are ignored and lost.
- Simultaneous edge and timeout expiry in the same cycle: the edge wins (status captured, timeout flag 0).
- `cmd_done` outside XFER is ignored.
- `frame_count` is 16-bit and wraps from 0xFFFF to 0.

## Timing
- Reset values: state IDLE; `desc_ready`=1 after reset deasserts.
- All other outputs reset to 0: `cmd_valid`, `cmd_*`, `wb_valid`, `wb_word`, `used_hit`, `dma_tx_end_tog`, `frame_count`.
- Reset mid-frame aborts immediately. No toggle and no writeback are emitted, and `dma_tx_end_tog` returns to 0.
- Descriptor accept at cycle t: `cmd_valid` high at t+1.
- `cmd_done` at cycle t:
  - last=1: `dma_tx_end_tog` flips at t+1.
  - last=0: `wb_valid` high at t+1.
- Status edge present on the input at cycle t: `wb_valid` high at t+1, with `tx_r_status` sampled at t.
- Timeout: `wb_valid` rises exactly `STATUS_TIMEOUT` cycles after `dma_tx_end_tog` flips, if no edge arrives.
- Handshakes follow valid/ready rules: valid never drops without ready, and payloads do not change while valid is high.
- Throughput: at most one descriptor is in flight. Minimum IDLE-to-IDLE for a non-last buffer is 4 cycles with ready held high and an immediate `cmd_done`.
- All outputs are registered.

## Test plan
- Single-buffer frame: desc 0x0000_8040 -> `cmd_length`=64, `cmd_last`=1. `cmd_done` -> `dma_tx_end_tog` flips. Status toggle with `tx_r_status`=0 -> `wb_word`=0x8000_8040, `frame_count`=1.
- Two-buffer frame: 0x0000_0100 then 0x4001_8020 -> first writeback is 0x8000_0100 with no toggle; second is 0xC001_8020 after the status toggle.
- Used descriptor 0x8000_8040 -> one-cycle `used_hit`, no `cmd_valid`, no `wb_valid`, `desc_ready` stays 1.
- Errors: `tx_r_status`=4'b1111 on the edge -> `wb_word`[29:26]=4'b1111. No edge with `STATUS_TIMEOUT`=8 -> `wb_valid` 8 cycles after the toggle, `wb_word`[27]=1. Edge coinciding with expiry -> [27]=0.
- Backpressure and zero length: `cmd_ready`/`wb_ready` low for 5 cycles -> payload stable. Length-0 last descriptor -> toggle with no `cmd_valid`.
- Reset during WAIT_STAT -> all outputs 0, `desc_ready` returns, a later status edge is ignored. `frame_count` wraps 0xFFFF -> 0.
